// File: rtl/channel_freq_meter_if.sv
`default_nettype none
// ============================================================================
// Module      : channel_freq_meter_if
// Description : Channel input controls and measurement results of the meter.
// Revision    : 1.0 - initial release
// ============================================================================
interface channel_freq_meter_if #(
    parameter int CNT_W = 32
);
    logic             CH_IN;
    logic             EN;
    logic             CLR;
    logic [CNT_W-1:0] HALF_PERIOD;
    logic             MEAS_VALID;
    logic             MEAS_LEVEL;
    logic             LOCKED;
    logic             TIMEOUT_FLAG;

    modport master (
        output CH_IN, EN, CLR,
        input  HALF_PERIOD, MEAS_VALID, MEAS_LEVEL, LOCKED, TIMEOUT_FLAG
    );

    modport slave (
        input  CH_IN, EN, CLR,
        output HALF_PERIOD, MEAS_VALID, MEAS_LEVEL, LOCKED, TIMEOUT_FLAG
    );
endinterface
`default_nettype wire

// File: rtl/channel_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : channel_freq_meter
// Description : Half-period meter for one channel pin with lock and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module channel_freq_meter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 100000,
    parameter int LOCK_COUNT  = 4,
    parameter int TOL         = 2
) (
    input logic                  clk_100MHz,
    input logic                  RSTN,
    channel_freq_meter_if.slave  bus
);
    localparam int               c_MC_W         = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_TOL          = CNT_W'(TOL);
    localparam logic [c_MC_W-1:0] c_LOCK_COUNT  = c_MC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_counter;
    logic [CNT_W-1:0]       r_prev_meas;
    logic                   r_prev_meas_valid;
    logic [c_MC_W-1:0]      r_match_cnt;

    logic                   w_sync_out;
    logic                   w_edge;
    logic [CNT_W-1:0]       w_new_meas;
    logic [CNT_W-1:0]       w_diff;
    logic [c_MC_W-1:0]      w_match_next;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_edge     = w_sync_out ^ r_prev;
    assign w_new_meas = r_counter + CNT_W'(1);

    // Difference taken as max-min so it never wraps.
    assign w_diff = (w_new_meas >= r_prev_meas) ? (w_new_meas - r_prev_meas)
                                                : (r_prev_meas - w_new_meas);

    always_comb begin
        w_match_next = '0;
        if (r_prev_meas_valid && (w_diff <= c_TOL)) begin
            w_match_next = (r_match_cnt == c_LOCK_COUNT) ? c_LOCK_COUNT
                                                         : r_match_cnt + c_MC_W'(1);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!RSTN) begin
            r_state           <= ST_IDLE;
            r_sync            <= '0;
            r_prev            <= 1'b0;
            r_counter         <= '0;
            r_prev_meas       <= '0;
            r_prev_meas_valid <= 1'b0;
            r_match_cnt       <= '0;
            bus.HALF_PERIOD   <= '0;
            bus.MEAS_VALID    <= 1'b0;
            bus.MEAS_LEVEL    <= 1'b0;
            bus.LOCKED        <= 1'b0;
            bus.TIMEOUT_FLAG  <= 1'b0;
        end else begin
            r_sync         <= {r_sync[SYNC_STAGES-2:0], bus.CH_IN};
            r_prev         <= w_sync_out;
            bus.MEAS_VALID <= 1'b0;
            // A timeout in the same cycle overrides this clear below.
            if (bus.CLR) begin
                bus.TIMEOUT_FLAG <= 1'b0;
            end
            if (!bus.EN) begin
                r_state           <= ST_IDLE;
                r_counter         <= '0;
                r_match_cnt       <= '0;
                r_prev_meas_valid <= 1'b0;
                bus.LOCKED        <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_counter         <= '0;
                        r_match_cnt       <= '0;
                        r_prev_meas_valid <= 1'b0;
                        bus.LOCKED        <= 1'b0;
                        r_state           <= ST_ARM;
                    end
                    ST_ARM: begin
                        r_counter <= '0;
                        if (w_edge) begin
                            r_prev_meas_valid <= 1'b0;
                            r_match_cnt       <= '0;
                            r_state           <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        if (w_edge) begin
                            bus.HALF_PERIOD   <= w_new_meas;
                            bus.MEAS_LEVEL    <= r_prev;
                            bus.MEAS_VALID    <= 1'b1;
                            bus.LOCKED        <= (w_match_next == c_LOCK_COUNT);
                            r_match_cnt       <= w_match_next;
                            r_prev_meas       <= w_new_meas;
                            r_prev_meas_valid <= 1'b1;
                            r_counter         <= '0;
                        end else if (r_counter == c_TIMEOUT_LAST) begin
                            bus.TIMEOUT_FLAG  <= 1'b1;
                            bus.LOCKED        <= 1'b0;
                            r_match_cnt       <= '0;
                            r_prev_meas_valid <= 1'b0;
                            r_counter         <= '0;
                            r_state           <= ST_ARM;
                        end else begin
                            r_counter <= r_counter + CNT_W'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
`default_nettype wire
